fwd_hazard_unit: RTL



---
 rtl/fwd_hazard_unit.sv | 136 +++++++++++++
 1 files changed

// File: rtl/fwd_hazard_unit.sv
// Shadow copy of EX/MEM/WB destination state beside the ID/EX register:
// drives the two ALU-operand forwarding selects and the load-use stall.
module fwd_hazard_unit #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             flush,
    output logic             stall,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cnt
);

    logic             ex_valid_q, ex_valid_d;
    logic [REG_W-1:0] ex_rs1_q, ex_rs1_d;
    logic [REG_W-1:0] ex_rs2_q, ex_rs2_d;
    logic             ex_rs1_used_q, ex_rs1_used_d;
    logic             ex_rs2_used_q, ex_rs2_used_d;
    logic [REG_W-1:0] ex_rd_q, ex_rd_d;
    logic             ex_reg_write_q, ex_reg_write_d;
    logic             ex_mem_read_q, ex_mem_read_d;

    logic             mem_valid_q;
    logic [REG_W-1:0] mem_rd_q;
    logic             mem_reg_write_q;

    logic             wb_valid_q;
    logic [REG_W-1:0] wb_rd_q;
    logic             wb_reg_write_q;

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // x0 is hardwired, so a write to it never produces a forwardable value.
    function automatic logic writes_reg(input logic             valid,
                                        input logic             reg_write,
                                        input logic [REG_W-1:0] rd,
                                        input logic [REG_W-1:0] r);
        return valid && reg_write && (rd == r) && (r != '0);
    endfunction

    // A flush kills the consumer in ID, so it never needs to wait on the load.
    always_comb begin
        stall = 1'b0;
        if (!flush && id_valid && ex_valid_q && ex_mem_read_q && (ex_rd_q != '0)) begin
            stall = (id_rs1_used && (id_rs1 == ex_rd_q)) ||
                    (id_rs2_used && (id_rs2 == ex_rd_q));
        end
    end

    always_comb begin
        ex_valid_d     = id_valid;
        ex_rs1_d       = id_rs1;
        ex_rs2_d       = id_rs2;
        ex_rs1_used_d  = id_rs1_used;
        ex_rs2_used_d  = id_rs2_used;
        ex_rd_d        = id_rd;
        ex_reg_write_d = id_reg_write;
        ex_mem_read_d  = id_mem_read;
        if (stall || flush) begin
            ex_valid_d = 1'b0;
        end

        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // MEM and WB simply trail EX; only EX can take a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q      <= 1'b0;
            ex_rs1_q        <= '0;
            ex_rs2_q        <= '0;
            ex_rs1_used_q   <= 1'b0;
            ex_rs2_used_q   <= 1'b0;
            ex_rd_q         <= '0;
            ex_reg_write_q  <= 1'b0;
            ex_mem_read_q   <= 1'b0;
            mem_valid_q     <= 1'b0;
            mem_rd_q        <= '0;
            mem_reg_write_q <= 1'b0;
            wb_valid_q      <= 1'b0;
            wb_rd_q         <= '0;
            wb_reg_write_q  <= 1'b0;
            stall_cnt_q     <= '0;
        end else begin
            ex_valid_q      <= ex_valid_d;
            ex_rs1_q        <= ex_rs1_d;
            ex_rs2_q        <= ex_rs2_d;
            ex_rs1_used_q   <= ex_rs1_used_d;
            ex_rs2_used_q   <= ex_rs2_used_d;
            ex_rd_q         <= ex_rd_d;
            ex_reg_write_q  <= ex_reg_write_d;
            ex_mem_read_q   <= ex_mem_read_d;
            mem_valid_q     <= ex_valid_q;
            mem_rd_q        <= ex_rd_q;
            mem_reg_write_q <= ex_reg_write_q;
            wb_valid_q      <= mem_valid_q;
            wb_rd_q         <= mem_rd_q;
            wb_reg_write_q  <= mem_reg_write_q;
            stall_cnt_q     <= stall_cnt_d;
        end
    end

    // MEM holds the newer value, so it is checked before WB.
    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (ex_valid_q) begin
            if (ex_rs1_used_q && writes_reg(mem_valid_q, mem_reg_write_q, mem_rd_q, ex_rs1_q)) begin
                fwd_a = 2'b01;
            end else if (ex_rs1_used_q && writes_reg(wb_valid_q, wb_reg_write_q, wb_rd_q, ex_rs1_q)) begin
                fwd_a = 2'b10;
            end
            if (ex_rs2_used_q && writes_reg(mem_valid_q, mem_reg_write_q, mem_rd_q, ex_rs2_q)) begin
                fwd_b = 2'b01;
            end else if (ex_rs2_used_q && writes_reg(wb_valid_q, wb_reg_write_q, wb_rd_q, ex_rs2_q)) begin
                fwd_b = 2'b10;
            end
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule
